// File: rtl/io_test_sequencer.sv
// io_test_sequencer: run controller for the io_test trigger-level measurement block.
// It pulses meas_start, waits for the synchronised AFG return trigger, lets the
// counters settle, then accumulates the four io_test timestamps over N runs.
// Optional feature macro: IO_TEST_SEQ_MINMAX_EN (min/max tracking of counts_ch1_high).
module io_test_sequencer #(
    parameter int unsigned RUNS_W        = 16,
    parameter int unsigned SUM_W         = 48,
    parameter int unsigned START_HOLD    = 4,
    parameter int unsigned SETTLE_CYCLES = 250
) (
    input  logic              clk_250mhz,
    input  logic              rst,
    input  logic              cfg_start,
    input  logic              cfg_abort,
    input  logic [RUNS_W-1:0] cfg_num_runs,
    input  logic [31:0]       cfg_timeout,
    input  logic [7:0]        cfg_high_delay,
    input  logic              trigger_in_afg,
    input  logic [31:0]       counts_ch1_high,
    input  logic [31:0]       counts_ch1_low,
    input  logic [31:0]       counts_ch2_high,
    input  logic [31:0]       counts_ch2_low,
    output logic              meas_start,
    output logic [7:0]        meas_high_delay,
    output logic              busy,
    output logic              done,
    output logic              timed_out,
    output logic              aborted,
    output logic [RUNS_W-1:0] runs_done,
    output logic [SUM_W-1:0]  sum_ch1_high,
    output logic [SUM_W-1:0]  sum_ch1_low,
    output logic [SUM_W-1:0]  sum_ch2_high,
    output logic [SUM_W-1:0]  sum_ch2_low,
    output logic [RUNS_W-1:0] miss_ch1,
    output logic [RUNS_W-1:0] miss_ch2,
    output logic [31:0]       min_ch1_high,
    output logic [31:0]       max_ch1_high
);

    localparam int unsigned TS_W  = 32;
    localparam int unsigned SUM_X = SUM_W + 1;
    localparam int unsigned PH_W  = $clog2(SETTLE_CYCLES + START_HOLD) + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_WAIT,
        S_SETTLE,
        S_CAPTURE,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [PH_W-1:0]   ph_cnt_q, ph_cnt_d;
    logic [TS_W-1:0]   tmo_cnt_q, tmo_cnt_d;
    logic              start_q;
    logic [2:0]        afg_sync_q;

    logic              start_rise;
    logic              afg_rise;
    logic              run_busy;

    logic              meas_start_d, busy_d, done_d, timed_out_d, aborted_d;
    logic [7:0]        high_delay_d;
    logic [RUNS_W-1:0] runs_d, miss1_d, miss2_d;
    logic [SUM_W-1:0]  s1h_d, s1l_d, s2h_d, s2l_d;
`ifdef IO_TEST_SEQ_MINMAX_EN
    logic [TS_W-1:0]   min_d, max_d;
`endif

    // Saturating accumulate of a zero-extended timestamp
    function automatic logic [SUM_W-1:0] sat_add(input logic [SUM_W-1:0] a,
                                                 input logic [TS_W-1:0]  b);
        logic [SUM_W:0] t;
        t = {1'b0, a} + SUM_X'(b);
        return t[SUM_W] ? '1 : t[SUM_W-1:0];
    endfunction

    assign start_rise = cfg_start & ~start_q;
    assign afg_rise   = afg_sync_q[1] & ~afg_sync_q[2];
    assign run_busy   = (state_q == S_ARM) || (state_q == S_WAIT) ||
                        (state_q == S_SETTLE) || (state_q == S_CAPTURE);

    // Next-state and next-output computation
    always_comb begin
        state_d      = state_q;
        ph_cnt_d     = ph_cnt_q;
        tmo_cnt_d    = tmo_cnt_q;
        high_delay_d = meas_high_delay;
        timed_out_d  = timed_out;
        aborted_d    = aborted;
        runs_d       = runs_done;
        miss1_d      = miss_ch1;
        miss2_d      = miss_ch2;
        s1h_d        = sum_ch1_high;
        s1l_d        = sum_ch1_low;
        s2h_d        = sum_ch2_high;
        s2l_d        = sum_ch2_low;
`ifdef IO_TEST_SEQ_MINMAX_EN
        min_d        = min_ch1_high;
        max_d        = max_ch1_high;
`endif

        if (run_busy && cfg_abort) begin
            aborted_d = 1'b1;
            state_d   = S_DONE;
        end else begin
            unique case (state_q)
                S_IDLE, S_DONE: begin
                    if (start_rise) begin
                        high_delay_d = cfg_high_delay;
                        timed_out_d  = 1'b0;
                        aborted_d    = 1'b0;
                        runs_d       = '0;
                        miss1_d      = '0;
                        miss2_d      = '0;
                        s1h_d        = '0;
                        s1l_d        = '0;
                        s2h_d        = '0;
                        s2l_d        = '0;
`ifdef IO_TEST_SEQ_MINMAX_EN
                        min_d        = '1;
                        max_d        = '0;
`endif
                        ph_cnt_d     = '0;
                        tmo_cnt_d    = '0;
                        state_d      = (cfg_num_runs == '0) ? S_DONE : S_ARM;
                    end
                end
                S_ARM: begin
                    tmo_cnt_d = '0;
                    if (ph_cnt_q == PH_W'(START_HOLD - 1)) begin
                        ph_cnt_d = '0;
                        state_d  = S_WAIT;
                    end else begin
                        ph_cnt_d = ph_cnt_q + PH_W'(1);
                    end
                end
                S_WAIT: begin
                    if (afg_rise) begin
                        ph_cnt_d = '0;
                        state_d  = S_SETTLE;
                    end else if ((cfg_timeout != '0) && (tmo_cnt_q == cfg_timeout)) begin
                        timed_out_d = 1'b1;
                        state_d     = S_DONE;
                    end else begin
                        tmo_cnt_d = tmo_cnt_q + TS_W'(1);
                    end
                end
                S_SETTLE: begin
                    if (ph_cnt_q == PH_W'(SETTLE_CYCLES - 1)) begin
                        ph_cnt_d = '0;
                        state_d  = S_CAPTURE;
                    end else begin
                        ph_cnt_d = ph_cnt_q + PH_W'(1);
                    end
                end
                S_CAPTURE: begin
                    s1h_d = sat_add(sum_ch1_high, counts_ch1_high);
                    s1l_d = sat_add(sum_ch1_low,  counts_ch1_low);
                    s2h_d = sat_add(sum_ch2_high, counts_ch2_high);
                    s2l_d = sat_add(sum_ch2_low,  counts_ch2_low);
                    if ((counts_ch1_high == TS_W'(1)) || (counts_ch1_low == TS_W'(1)))
                        miss1_d = miss_ch1 + RUNS_W'(1);
                    if ((counts_ch2_high == TS_W'(1)) || (counts_ch2_low == TS_W'(1)))
                        miss2_d = miss_ch2 + RUNS_W'(1);
`ifdef IO_TEST_SEQ_MINMAX_EN
                    if (counts_ch1_high != TS_W'(1)) begin
                        if (counts_ch1_high < min_ch1_high) min_d = counts_ch1_high;
                        if (counts_ch1_high > max_ch1_high) max_d = counts_ch1_high;
                    end
`endif
                    runs_d   = runs_done + RUNS_W'(1);
                    ph_cnt_d = '0;
                    state_d  = ((runs_done + RUNS_W'(1)) == cfg_num_runs) ? S_DONE : S_ARM;
                end
                default: state_d = S_IDLE;
            endcase
        end

        meas_start_d = (state_d == S_ARM);
        busy_d       = (state_d == S_ARM) || (state_d == S_WAIT) ||
                       (state_d == S_SETTLE) || (state_d == S_CAPTURE);
        done_d       = (state_d == S_DONE);
    end

    // State, synchronisers and registered outputs
    always_ff @(posedge clk_250mhz or posedge rst) begin
        if (rst) begin
            state_q         <= S_IDLE;
            ph_cnt_q        <= '0;
            tmo_cnt_q       <= '0;
            start_q         <= 1'b0;
            afg_sync_q      <= '0;
            meas_start      <= 1'b0;
            meas_high_delay <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
            timed_out       <= 1'b0;
            aborted         <= 1'b0;
            runs_done       <= '0;
            miss_ch1        <= '0;
            miss_ch2        <= '0;
            sum_ch1_high    <= '0;
            sum_ch1_low     <= '0;
            sum_ch2_high    <= '0;
            sum_ch2_low     <= '0;
        end else begin
            state_q         <= state_d;
            ph_cnt_q        <= ph_cnt_d;
            tmo_cnt_q       <= tmo_cnt_d;
            start_q         <= cfg_start;
            afg_sync_q      <= {afg_sync_q[1:0], trigger_in_afg};
            meas_start      <= meas_start_d;
            meas_high_delay <= high_delay_d;
            busy            <= busy_d;
            done            <= done_d;
            timed_out       <= timed_out_d;
            aborted         <= aborted_d;
            runs_done       <= runs_d;
            miss_ch1        <= miss1_d;
            miss_ch2        <= miss2_d;
            sum_ch1_high    <= s1h_d;
            sum_ch1_low     <= s1l_d;
            sum_ch2_high    <= s2h_d;
            sum_ch2_low     <= s2l_d;
        end
    end

`ifdef IO_TEST_SEQ_MINMAX_EN
    // Min/max of valid ch1 high timestamps across the sequence
    always_ff @(posedge clk_250mhz or posedge rst) begin
        if (rst) begin
            min_ch1_high <= '0;
            max_ch1_high <= '0;
        end else begin
            min_ch1_high <= min_d;
            max_ch1_high <= max_d;
        end
    end
`else
    assign min_ch1_high = '0;
    assign max_ch1_high = '0;
`endif

endmodule

// File: tb/tb_io_test_sequencer.sv
// Self-checking bench for io_test_sequencer: an AFG echo responder supplies the
// return trigger and per-run timestamps; expected results come from a run-table model.
module tb_io_test_sequencer;

    logic        clk_250mhz = 1'b0;
    logic        rst;
    logic        cfg_start, cfg_abort;
    logic [15:0] cfg_num_runs;
    logic [31:0] cfg_timeout;
    logic [7:0]  cfg_high_delay;
    logic        trigger_in_afg;
    logic [31:0] counts_ch1_high, counts_ch1_low, counts_ch2_high, counts_ch2_low;
    logic        meas_start, busy, done, timed_out, aborted;
    logic [7:0]  meas_high_delay;
    logic [15:0] runs_done, miss_ch1, miss_ch2;
    logic [47:0] sum_ch1_high, sum_ch1_low, sum_ch2_high, sum_ch2_low;
    logic [31:0] min_ch1_high, max_ch1_high;

    int n_checks = 0;
    int n_fail   = 0;

    // Per-run timestamp table: [channel: ch1h, ch1l, ch2h, ch2l][run]
    int unsigned tbl [4][8];
    int  seq_run     = 0;
    int  pulse_total = 0;
    int  last_width  = 0;
    int  cur_width   = 0;
    bit  ms_prev     = 1'b0;
    bit  echo_en     = 1'b1;
    int  echo_delay  = 100;
    int  echo_cd     = 0;
    int  trig_hold   = 0;

    always #2 clk_250mhz = ~clk_250mhz;

    io_test_sequencer dut (
        .clk_250mhz      (clk_250mhz),
        .rst             (rst),
        .cfg_start       (cfg_start),
        .cfg_abort       (cfg_abort),
        .cfg_num_runs    (cfg_num_runs),
        .cfg_timeout     (cfg_timeout),
        .cfg_high_delay  (cfg_high_delay),
        .trigger_in_afg  (trigger_in_afg),
        .counts_ch1_high (counts_ch1_high),
        .counts_ch1_low  (counts_ch1_low),
        .counts_ch2_high (counts_ch2_high),
        .counts_ch2_low  (counts_ch2_low),
        .meas_start      (meas_start),
        .meas_high_delay (meas_high_delay),
        .busy            (busy),
        .done            (done),
        .timed_out       (timed_out),
        .aborted         (aborted),
        .runs_done       (runs_done),
        .sum_ch1_high    (sum_ch1_high),
        .sum_ch1_low     (sum_ch1_low),
        .sum_ch2_high    (sum_ch2_high),
        .sum_ch2_low     (sum_ch2_low),
        .miss_ch1        (miss_ch1),
        .miss_ch2        (miss_ch2),
        .min_ch1_high    (min_ch1_high),
        .max_ch1_high    (max_ch1_high)
    );

    // AFG stand-in: on each meas_start rise present that run's timestamps and echo a trigger
    initial begin
        forever begin
            @(negedge clk_250mhz);
            if (meas_start && !ms_prev) begin
                pulse_total++;
                if (seq_run < 8) begin
                    counts_ch1_high = tbl[0][seq_run];
                    counts_ch1_low  = tbl[1][seq_run];
                    counts_ch2_high = tbl[2][seq_run];
                    counts_ch2_low  = tbl[3][seq_run];
                end
                seq_run++;
                if (echo_en) echo_cd = echo_delay;
            end
            if (meas_start) cur_width++;
            else if (ms_prev) begin
                last_width = cur_width;
                cur_width  = 0;
            end
            ms_prev = meas_start;
            if (echo_cd > 0) begin
                echo_cd--;
                if (echo_cd == 0) trig_hold = 4;
            end
            trigger_in_afg = (trig_hold > 0);
            if (trig_hold > 0) trig_hold--;
        end
    end

    // Reference model: results implied by the first n rows of the run table
    function automatic logic [47:0] model_sum(input int ch, input int n);
        logic [63:0] s;
        s = 64'd0;
        for (int r = 0; r < n; r++) begin
            s = s + 64'(tbl[ch][r]);
            if (s > 64'h0000_FFFF_FFFF_FFFF) s = 64'h0000_FFFF_FFFF_FFFF;
        end
        return s[47:0];
    endfunction

    function automatic int model_miss(input int chn, input int n);
        int m;
        m = 0;
        for (int r = 0; r < n; r++)
            if (tbl[2*chn][r] == 1 || tbl[2*chn+1][r] == 1) m++;
        return m;
    endfunction

`ifdef IO_TEST_SEQ_MINMAX_EN
    function automatic logic [31:0] model_min(input int n);
        logic [31:0] m;
        m = 32'hFFFF_FFFF;
        for (int r = 0; r < n; r++)
            if (tbl[0][r] != 1 && tbl[0][r] < m) m = tbl[0][r];
        return m;
    endfunction

    function automatic logic [31:0] model_max(input int n);
        logic [31:0] m;
        m = 32'd0;
        for (int r = 0; r < n; r++)
            if (tbl[0][r] != 1 && tbl[0][r] > m) m = tbl[0][r];
        return m;
    endfunction
`endif

    function automatic logic [47:0] dut_sum(input int ch);
        case (ch)
            0:       return sum_ch1_high;
            1:       return sum_ch1_low;
            2:       return sum_ch2_high;
            default: return sum_ch2_low;
        endcase
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk_250mhz);
    endtask

    task automatic set_run(input int r, input int unsigned a, input int unsigned b,
                           input int unsigned c, input int unsigned d);
        tbl[0][r] = a; tbl[1][r] = b; tbl[2][r] = c; tbl[3][r] = d;
    endtask

    task automatic start_seq(input int n, input int unsigned tmo);
        cfg_num_runs = 16'(n);
        cfg_timeout  = tmo;
        seq_run      = 0;
        echo_cd      = 0;
        trig_hold    = 0;
        cfg_start    = 1'b1;
        @(negedge clk_250mhz);
        cfg_start    = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int cyc);
        cyc = 0;
        while (!done && cyc < budget) begin
            @(negedge clk_250mhz);
            cyc++;
        end
        if (!done) cyc = -1;
    endtask

    task automatic test_reset();
        n_checks++;
        if ({meas_start, busy, done, timed_out, aborted} !== 5'b0 || runs_done !== 16'd0 ||
            sum_ch1_high !== 48'd0 || sum_ch2_low !== 48'd0 || miss_ch1 !== 16'd0 ||
            miss_ch2 !== 16'd0 || meas_high_delay !== 8'd0 ||
            min_ch1_high !== 32'd0 || max_ch1_high !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_state: flags=%b runs=%0d sum1h=%0d, required all zero",
                     {meas_start, busy, done, timed_out, aborted}, runs_done, sum_ch1_high);
        end
    endtask

    task automatic test_basic();
        int cyc;
        for (int r = 0; r < 3; r++) set_run(r, 40, 90, 50, 95);
        echo_en = 1'b1; echo_delay = 100;
        start_seq(3, 0);
        n_checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_busy: busy=%b done=%b, required busy=1 done=0", busy, done);
        end
        wait_done(3000, cyc);
        n_checks++;
        if (cyc < 0 || runs_done !== 16'd3 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_done: cyc=%0d runs=%0d busy=%b, required done with 3 runs", cyc, runs_done, busy);
        end
        n_checks++;
        if (sum_ch1_high !== 48'd120 || sum_ch1_low !== 48'd270 ||
            sum_ch2_high !== 48'd150 || sum_ch2_low !== 48'd285) begin
            n_fail++;
            $display("FAIL basic_sums: got %0d/%0d/%0d/%0d, required 120/270/150/285",
                     sum_ch1_high, sum_ch1_low, sum_ch2_high, sum_ch2_low);
        end
        n_checks++;
        if (miss_ch1 !== 16'd0 || miss_ch2 !== 16'd0 || timed_out !== 1'b0 || aborted !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_flags: miss %0d/%0d to=%b ab=%b, required all 0",
                     miss_ch1, miss_ch2, timed_out, aborted);
        end
        n_checks++;
        if (last_width !== 4) begin
            n_fail++;
            $display("FAIL basic_pulse_width: got %0d, required 4", last_width);
        end
    endtask

    task automatic test_random();
        int cyc, n;
        for (int it = 0; it < 3; it++) begin
            n = int'($urandom_range(1, 5));
            for (int r = 0; r < n; r++)
                for (int ch = 0; ch < 4; ch++)
                    tbl[ch][r] = ($urandom_range(0, 3) == 0) ? 1 : $urandom_range(2, 5000);
            echo_delay = int'($urandom_range(10, 150));
            start_seq(n, 2000);
            wait_done(n * 700 + 100, cyc);
            n_checks++;
            if (cyc < 0 || runs_done !== 16'(n) || timed_out !== 1'b0) begin
                n_fail++;
                $display("FAIL rand%0d_runs: cyc=%0d runs=%0d to=%b, required %0d runs",
                         it, cyc, runs_done, timed_out, n);
            end
            for (int ch = 0; ch < 4; ch++) begin
                n_checks++;
                if (dut_sum(ch) !== model_sum(ch, n)) begin
                    n_fail++;
                    $display("FAIL rand%0d_sum ch%0d: got %0d, required %0d",
                             it, ch, dut_sum(ch), model_sum(ch, n));
                end
            end
            n_checks++;
            if (miss_ch1 !== 16'(model_miss(0, n)) || miss_ch2 !== 16'(model_miss(1, n))) begin
                n_fail++;
                $display("FAIL rand%0d_miss: got %0d/%0d, required %0d/%0d", it,
                         miss_ch1, miss_ch2, model_miss(0, n), model_miss(1, n));
            end
        end
    endtask

    task automatic test_timeout();
        int cyc, base;
        echo_en = 1'b0;
        base = pulse_total;
        start_seq(2, 500);
        wait_done(2000, cyc);
        n_checks++;
        if (cyc < 498 || cyc > 512) begin
            n_fail++;
            $display("FAIL timeout_latency: got %0d cycles, required about 505", cyc);
        end
        n_checks++;
        if (timed_out !== 1'b1 || runs_done !== 16'd0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_flags: to=%b runs=%0d busy=%b, required to=1 runs=0 busy=0",
                     timed_out, runs_done, busy);
        end
        n_checks++;
        if (pulse_total - base !== 1 || last_width !== 4) begin
            n_fail++;
            $display("FAIL timeout_pulses: got %0d pulses width %0d, required 1 pulse width 4",
                     pulse_total - base, last_width);
        end
        echo_en = 1'b1;
    endtask

    task automatic test_zero_runs();
        int base;
        base = pulse_total;
        start_seq(0, 0);
        n_checks++;
        if (done !== 1'b1 || busy !== 1'b0 || runs_done !== 16'd0 || timed_out !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_runs_done: done=%b busy=%b runs=%0d, required done=1 one cycle after start",
                     done, busy, runs_done);
        end
        tick(20);
        n_checks++;
        if (pulse_total != base || meas_start !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_runs_pulse: got %0d pulses, required 0", pulse_total - base);
        end
    endtask

    task automatic test_miss();
        int cyc;
        for (int r = 0; r < 4; r++)
            if (r == 1 || r == 3) set_run(r, 200 + r, 300 + r, 1, 1);
            else set_run(r, 200 + r, 300 + r, 400 + r, 500 + r);
        echo_delay = 60;
        start_seq(4, 0);
        wait_done(3000, cyc);
        n_checks++;
        if (cyc < 0 || miss_ch2 !== 16'd2 || miss_ch1 !== 16'd0 || runs_done !== 16'd4) begin
            n_fail++;
            $display("FAIL miss_counts: cyc=%0d miss1=%0d miss2=%0d runs=%0d, required 0/2/4",
                     cyc, miss_ch1, miss_ch2, runs_done);
        end
        n_checks++;
        if (sum_ch2_high !== 48'd804 || sum_ch2_low !== model_sum(3, 4)) begin
            n_fail++;
            $display("FAIL miss_sums: ch2h=%0d ch2l=%0d, required 804 and %0d",
                     sum_ch2_high, sum_ch2_low, model_sum(3, 4));
        end
    endtask

    task automatic test_minmax();
        int cyc;
        set_run(0, 70, 10, 10, 10);
        set_run(1, 30, 10, 10, 10);
        set_run(2, 1, 10, 10, 10);
        set_run(3, 55, 10, 10, 10);
        echo_delay = 40;
        start_seq(4, 0);
        wait_done(3000, cyc);
        n_checks++;
`ifdef IO_TEST_SEQ_MINMAX_EN
        if (cyc < 0 || min_ch1_high !== 32'd30 || max_ch1_high !== 32'd70 ||
            min_ch1_high !== model_min(4) || max_ch1_high !== model_max(4)) begin
            n_fail++;
            $display("FAIL minmax: min=%0d max=%0d, required 30/70", min_ch1_high, max_ch1_high);
        end
`else
        if (cyc < 0 || min_ch1_high !== 32'd0 || max_ch1_high !== 32'd0) begin
            n_fail++;
            $display("FAIL minmax_off: min=%0d max=%0d, required 0/0", min_ch1_high, max_ch1_high);
        end
`endif
        n_checks++;
        if (miss_ch1 !== 16'd1) begin
            n_fail++;
            $display("FAIL minmax_miss1: got %0d, required 1", miss_ch1);
        end
    endtask

    task automatic test_back_to_back();
        int cyc, base;
        for (int r = 0; r < 2; r++) set_run(r, 11, 22, 33, 44);
        echo_delay = 80;
        cfg_high_delay = 8'h5A;
        base = pulse_total;
        start_seq(2, 0);
        cfg_high_delay = 8'hC3;
        tick(20);
        cfg_start = 1'b1;
        tick(2);
        cfg_start = 1'b0;
        n_checks++;
        if (busy !== 1'b1 || meas_high_delay !== 8'h5A) begin
            n_fail++;
            $display("FAIL b2b_busy: busy=%b hd=%h, required busy=1 hd=5a", busy, meas_high_delay);
        end
        wait_done(3000, cyc);
        n_checks++;
        if (cyc < 0 || runs_done !== 16'd2 || pulse_total - base !== 2 || sum_ch1_high !== 48'd22) begin
            n_fail++;
            $display("FAIL b2b_runs: runs=%0d pulses=%0d sum1h=%0d, required 2/2/22",
                     runs_done, pulse_total - base, sum_ch1_high);
        end
        tick(20);
        trig_hold = 4;
        tick(12);
        n_checks++;
        if (done !== 1'b1 || runs_done !== 16'd2 || meas_high_delay !== 8'h5A || meas_start !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_sticky: done=%b runs=%0d hd=%h, required done=1 runs=2 hd=5a",
                     done, runs_done, meas_high_delay);
        end
    endtask

    task automatic test_abort_reset();
        int base, cyc;
        for (int r = 0; r < 4; r++) set_run(r, 1000 + r, 2000, 3000, 4000);
        echo_delay = 100;
        base = pulse_total;
        start_seq(4, 0);
        cyc = 0;
        while (pulse_total < base + 2 && cyc < 2000) begin
            tick(1);
            cyc++;
        end
        tick(200);
        cfg_abort = 1'b1;
        tick(2);
        n_checks++;
        if (cyc >= 2000 || aborted !== 1'b1 || done !== 1'b1 || busy !== 1'b0 ||
            runs_done !== 16'd1 || meas_start !== 1'b0 || timed_out !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_state: ab=%b done=%b busy=%b runs=%0d ms=%b, required 1/1/0/1/0",
                     aborted, done, busy, runs_done, meas_start);
        end
        n_checks++;
        if (sum_ch1_high !== model_sum(0, 1)) begin
            n_fail++;
            $display("FAIL abort_sum: got %0d, required %0d", sum_ch1_high, model_sum(0, 1));
        end
        cfg_abort = 1'b0;
        tick(300);
        cfg_high_delay = 8'h77;
        start_seq(3, 0);
        tick(1);
        rst = 1'b1;
        #1;
        n_checks++;
        if (meas_start !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_async_meas_start: got %b, required 0", meas_start);
        end
        tick(1);
        n_checks++;
        if ({meas_start, busy, done, timed_out, aborted} !== 5'b0 || runs_done !== 16'd0 ||
            sum_ch1_high !== 48'd0 || meas_high_delay !== 8'd0 || miss_ch1 !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_midrun: flags=%b runs=%0d hd=%h, required all zero",
                     {meas_start, busy, done, timed_out, aborted}, runs_done, meas_high_delay);
        end
        rst = 1'b0;
        tick(300);
    endtask

    initial begin
        rst = 1'b1;
        cfg_start = 1'b0; cfg_abort = 1'b0;
        cfg_num_runs = 16'd0; cfg_timeout = 32'd0; cfg_high_delay = 8'h12;
        trigger_in_afg = 1'b0;
        counts_ch1_high = 32'd0; counts_ch1_low = 32'd0;
        counts_ch2_high = 32'd0; counts_ch2_low = 32'd0;
        for (int ch = 0; ch < 4; ch++)
            for (int r = 0; r < 8; r++) tbl[ch][r] = 0;
        tick(3);
        test_reset();
        rst = 1'b0;
        tick(3);
        test_reset();
        test_basic();
        test_random();
        test_timeout();
        test_zero_runs();
        test_miss();
        test_minmax();
        test_back_to_back();
        test_abort_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
